// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
//   - funct3 access-size encodings for loads and stores
//   - MMIO base address and register offsets for the timer block
//   - RAM region tag (upper address half selecting the data RAM)
package dmem_pkg;

  // funct3 encodings; stores reuse the same size codes as signed loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // MMIO block sits at the top 64 KiB page; registers are word-spaced
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    MMIO_MTIME    = 2'd0,
    MMIO_MTIMECMP = 2'd1,
    MMIO_STATUS   = 2'd2
  } mmio_sel_e;

  localparam logic [15:0] RAM_REGION_TAG = 16'h0000;

  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped machine timer.
//   MTIME    free-running 32-bit counter, wraps, loadable by a store
//   MTIMECMP compare register
//   STATUS   bit0 = sticky pending flag, write 1 to clear
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   we            legal word store to this block this cycle
//   sel           register select (decoded from address bits [3:2])
//   wdata         store data
//   rdata         combinational read of the selected register
//   timer_irq     registered pending flag
import dmem_pkg::*;

module mmio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  mmio_sel_e   sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_irq
);

  logic [31:0] mtime_q;
  logic [31:0] mtimecmp_q;
  logic        pending_q;
  logic        irq_set;
  logic        irq_clr;

  // Compare uses the registered values, so a new MTIMECMP takes effect a
  // cycle after it is written and the flag rises the cycle after a match.
  assign irq_set = (mtime_q == mtimecmp_q);
  assign irq_clr = we && (sel == MMIO_STATUS) && wdata[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      pending_q  <= 1'b0;
    end else begin
      if (we && (sel == MMIO_MTIME)) mtime_q <= wdata;
      else                           mtime_q <= mtime_q + 32'd1;
      if (we && (sel == MMIO_MTIMECMP)) mtimecmp_q <= wdata;
      // set has priority over a simultaneous clear
      pending_q <= irq_set || (pending_q && !irq_clr);
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      MMIO_MTIME:    rdata = mtime_q;
      MMIO_MTIMECMP: rdata = mtimecmp_q;
      MMIO_STATUS:   rdata = {31'd0, pending_q};
      default:       rdata = '0;
    endcase
  end

  assign timer_irq = pending_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory responder for the core's Dmem port.
// Holds a word-organised RAM with byte-enable writes, lane steering with
// sign/zero extension for loads, misalignment/illegal-size detection, and
// the MMIO timer.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   addr_Dmem     byte address (ALU result)
//   DataW_Dmem    store data (low bits used for sub-word stores)
//   MemRW         1 = store this cycle
//   funct3        access size / signedness
//   DataR         combinational load data
//   access_err    combinational misaligned / illegal access flag
//   timer_irq     registered sticky timer interrupt
import dmem_pkg::*;

module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_Dmem,
  input  logic [DATA_WIDTH-1:0] DataW_Dmem,
  input  logic                  MemRW,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] DataR,
  output logic                  access_err,
  output logic                  timer_irq
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] ram_idx;
  logic             ram_in_range;
  logic             ram_hit;
  logic             mmio_hit;
  logic             size_half;
  logic             size_word;
  logic             misaligned;
  logic             store_ok;
  logic             ram_we;
  logic             timer_we;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      timer_rdata;
  logic [31:0]      word_rd;
  logic [7:0]       byte_rd;
  logic [15:0]      half_rd;
  mmio_sel_e        mmio_sel;

  // Words whose index does not fit the array are treated as unmapped rather
  // than aliased onto lower words.
  assign ram_idx      = addr_Dmem[IDX_W+1:2];
  assign ram_in_range = ({18'd0, addr_Dmem[15:2]} < 32'(DEPTH_WORDS));
  assign ram_hit      = (addr_Dmem[31:16] == RAM_REGION_TAG) && ram_in_range;

  // Any byte inside one of the three register words counts as MMIO, so a
  // sub-word access there is flagged instead of silently ignored.
  assign mmio_hit = (addr_Dmem[31:4] == MMIO_BASE[31:4]) && (addr_Dmem[3:2] != 2'b11);
  assign mmio_sel = mmio_sel_e'(addr_Dmem[3:2]);

  assign size_half  = (funct3[1:0] == 2'b01);
  assign size_word  = (funct3[1:0] == 2'b10);
  assign misaligned = (size_half && addr_Dmem[0]) ||
                      (size_word && (addr_Dmem[1:0] != 2'b00));
  assign access_err = !f3_is_legal(funct3) || misaligned ||
                      (mmio_hit && (funct3 != F3_LW));

  assign store_ok = MemRW && !access_err;
  assign ram_we   = store_ok && ram_hit && !reset;
  assign timer_we = store_ok && mmio_hit;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = DataW_Dmem;
    case (funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << addr_Dmem[1:0];
        wdata_rep = {4{DataW_Dmem[7:0]}};
      end
      2'b01: begin
        byte_en   = addr_Dmem[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{DataW_Dmem[15:0]}};
      end
      2'b10: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[ram_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .we        (timer_we),
    .sel       (mmio_sel),
    .wdata     (DataW_Dmem),
    .rdata     (timer_rdata),
    .timer_irq (timer_irq)
  );

  always_comb begin
    word_rd = '0;
    if (ram_hit)       word_rd = mem[ram_idx];
    else if (mmio_hit) word_rd = timer_rdata;
  end

  always_comb begin
    byte_rd = word_rd[8*addr_Dmem[1:0] +: 8];
    half_rd = addr_Dmem[1] ? word_rd[31:16] : word_rd[15:0];
  end

  always_comb begin
    DataR = '0;
    if (!access_err) begin
      case (funct3)
        F3_LB:   DataR = {{24{byte_rd[7]}}, byte_rd};
        F3_LBU:  DataR = {24'd0, byte_rd};
        F3_LH:   DataR = {{16{half_rd[15]}}, half_rd};
        F3_LHU:  DataR = {16'd0, half_rd};
        F3_LW:   DataR = word_rd;
        default: DataR = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                         LBU = 3'b100, LHU = 3'b101;
  localparam logic [31:0] A_MTIME = 32'hFFFF_0000, A_CMP = 32'hFFFF_0004,
                          A_STAT = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_Dmem = '0;
  logic [31:0] DataW_Dmem = '0;
  logic        MemRW = 1'b0;
  logic [2:0]  funct3 = LW;
  logic [31:0] DataR;
  logic        access_err;
  logic        timer_irq;

  int n_vec = 0;
  int n_err = 0;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .addr_Dmem  (addr_Dmem),
    .DataW_Dmem (DataW_Dmem),
    .MemRW      (MemRW),
    .funct3     (funct3),
    .DataR      (DataR),
    .access_err (access_err),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic [2:0] f3);
    addr_Dmem  = a;
    DataW_Dmem = d;
    MemRW      = we;
    funct3     = f3;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    drive(a, d, 1'b1, f3);
    tick;
    MemRW = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    n_vec++;
    if (timer_irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b want 0", timer_irq);
    end
    tick;
    reset = 1'b0;
    drive(A_MTIME, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h0) begin
      n_err++; $display("FAIL reset_mtime: got %h want 00000000", DataR);
    end
    drive(A_CMP, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL reset_mtimecmp: got %h want ffffffff", DataR);
    end
    drive(A_STAT, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h0) begin
      n_err++; $display("FAIL reset_status: got %h want 00000000", DataR);
    end
  endtask

  task automatic test_loads;
    logic [31:0] a  [8] = '{32'h10, 32'h11, 32'h12, 32'h10, 32'h10, 32'h13, 32'h12, 32'h10};
    logic [2:0]  f  [8] = '{LB, LBU, LH, LHU, LW, LB, LBU, LH};
    logic [31:0] ex [8] = '{32'hFFFF_FFBB, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_AABB,
                            32'h8899_AABB, 32'hFFFF_FF88, 32'h0000_0099, 32'hFFFF_AABB};
    store(32'h10, 32'h8899_AABB, LW);
    for (int i = 0; i < 8; i++) begin
      drive(a[i], 0, 1'b0, f[i]);
      n_vec++;
      if (DataR !== ex[i] || access_err !== 1'b0) begin
        n_err++;
        $display("FAIL load_%0d addr %h f3 %b: got %h err %b want %h err 0",
                 i, a[i], f[i], DataR, access_err, ex[i]);
      end
    end
  endtask

  task automatic test_store_lanes;
    store(32'h11, 32'hDEAD_BE55, LB);
    drive(32'h10, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h8899_55BB) begin
      n_err++; $display("FAIL sb_lane1: got %h want 889955bb", DataR);
    end
    store(32'h12, 32'hCAFE_1234, LH);
    drive(32'h10, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h1234_55BB) begin
      n_err++; $display("FAIL sh_upper: got %h want 123455bb", DataR);
    end
    store(32'h40, 32'h1111_1111, LW);
    drive(32'h40, 32'h2222_2222, 1'b1, LW);
    n_vec++;
    if (DataR !== 32'h1111_1111) begin
      n_err++; $display("FAIL same_cycle_old: got %h want 11111111", DataR);
    end
    tick;
    drive(32'h40, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h2222_2222) begin
      n_err++; $display("FAIL store_visible: got %h want 22222222", DataR);
    end
  endtask

  task automatic test_errors;
    logic [31:0] a [4] = '{32'h13, 32'h12, 32'h10, A_MTIME};
    logic [2:0]  f [4] = '{LH, LW, 3'b011, LB};
    logic        w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(a[i], 32'hFFFF_FFFF, w[i], f[i]);
      n_vec++;
      if (access_err !== 1'b1 || DataR !== 32'h0) begin
        n_err++;
        $display("FAIL err_%0d addr %h f3 %b: got err %b data %h want err 1 data 0",
                 i, a[i], f[i], access_err, DataR);
      end
      tick;
      MemRW = 1'b0;
    end
    store(32'h1010, 32'hA5A5_A5A5, LW);
    store(32'h0001_0010, 32'h5A5A_5A5A, LW);
    drive(32'h1010, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h0 || access_err !== 1'b0) begin
      n_err++; $display("FAIL out_of_range: got %h err %b want 0 err 0", DataR, access_err);
    end
    drive(32'h0001_0010, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h0 || access_err !== 1'b0) begin
      n_err++; $display("FAIL unmapped: got %h err %b want 0 err 0", DataR, access_err);
    end
    drive(32'h10, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h1234_55BB) begin
      n_err++; $display("FAIL mem_unchanged: got %h want 123455bb", DataR);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] ex [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    store(A_MTIME, 32'hFFFF_FFFE, LW);
    for (int i = 0; i < 3; i++) begin
      drive(A_MTIME, 0, 1'b0, LW);
      n_vec++;
      if (DataR !== ex[i]) begin
        n_err++; $display("FAIL wrap_%0d: got %h want %h", i, DataR, ex[i]);
      end
      tick;
    end
  endtask

  task automatic test_timer_irq;
    store(A_MTIME, 32'd100, LW);
    store(A_CMP, 32'd20, LW);
    store(A_STAT, 32'd1, LW);
    store(A_MTIME, 32'd15, LW);
    for (int k = 0; k <= 8; k++) begin
      drive(A_MTIME, 0, 1'b0, LW);
      n_vec++;
      if (DataR !== 32'(15 + k) || timer_irq !== (k >= 6)) begin
        n_err++;
        $display("FAIL irq_cycle_%0d: mtime %0d irq %b want mtime %0d irq %b",
                 k, DataR, timer_irq, 15 + k, (k >= 6));
      end
      tick;
    end
    store(A_STAT, 32'd1, LW);
    n_vec++;
    if (timer_irq !== 1'b0) begin
      n_err++; $display("FAIL irq_clear: got %b want 0", timer_irq);
    end
    store(A_MTIME, 32'd19, LW);
    tick;
    n_vec++;
    if (timer_irq !== 1'b0) begin
      n_err++; $display("FAIL irq_before_match: got %b want 0", timer_irq);
    end
    store(A_STAT, 32'd1, LW);
    n_vec++;
    if (timer_irq !== 1'b1) begin
      n_err++; $display("FAIL irq_set_wins: got %b want 1", timer_irq);
    end
    drive(A_STAT, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h1) begin
      n_err++; $display("FAIL status_read: got %h want 00000001", DataR);
    end
  endtask

  task automatic test_reset_mid;
    store(32'h20, 32'h0BAD_F00D, LW);
    reset = 1'b1;
    drive(32'h20, 32'h1234_5678, 1'b1, LW);
    tick;
    reset = 1'b0;
    drive(A_MTIME, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h0 || timer_irq !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_timer: mtime %h irq %b want 0 0", DataR, timer_irq);
    end
    tick;
    drive(A_CMP, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL rst_mid_cmp: got %h want ffffffff", DataR);
    end
    drive(32'h20, 0, 1'b0, LW);
    n_vec++;
    if (DataR !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL rst_mid_store_dropped: got %h want 0badf00d", DataR);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_store_lanes;
    test_errors;
    test_wrap;
    test_timer_irq;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
